// File: rtl/muldiv_pkg.sv
// Shared definitions for the mult/div sequencer and the HIGH/LOW input muxes.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    WRITE,
    DIV0,
    TMO
  } muldiv_state_t;

  localparam logic HILO_SRC_MULT = 1'b0;
  localparam logic HILO_SRC_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_seq.sv
// Sequencer for the multiply/divide units: start pulse, bounded wait for completion,
// then HIGH/LOW write, divide-by-zero or timeout report.
import muldiv_pkg::*;

module muldiv_seq #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic op_valid,
  input  logic op_is_div,
  input  logic abort,
  input  logic mult_end,
  input  logic div_end,
  input  logic div_zero,
  output logic op_ready,
  output logic busy,
  output logic mult_start,
  output logic div_start,
  output logic hilo_src,
  output logic hi_write,
  output logic lo_write,
  output logic done,
  output logic div0_exc,
  output logic timeout_exc
);

  muldiv_state_t    state_q;
  logic             kind_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sel_end;

  // Only the unit that was started may complete the operation.
  assign sel_end = kind_q ? div_end : mult_end;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      kind_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_valid) begin
            state_q <= START;
            kind_q  <= op_is_div;
          end
        end
        START: begin
          cnt_q   <= '0;
          state_q <= abort ? IDLE : WAIT;
        end
        WAIT: begin
          // div_zero outranks div_end so a zero divisor never reaches HIGH/LOW.
          if (abort) begin
            state_q <= IDLE;
          end else if (kind_q && div_zero) begin
            state_q <= DIV0;
          end else if (sel_end) begin
            state_q <= WRITE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q <= TMO;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WRITE, DIV0, TMO: state_q <= IDLE;
        default:          state_q <= IDLE;
      endcase
    end
  end

  assign op_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign mult_start  = (state_q == START) && !kind_q;
  assign div_start   = (state_q == START) &&  kind_q;
  assign hilo_src    = kind_q ? HILO_SRC_DIV : HILO_SRC_MULT;
  assign hi_write    = (state_q == WRITE);
  assign lo_write    = (state_q == WRITE);
  assign done        = (state_q == WRITE);
  assign div0_exc    = (state_q == DIV0);
  assign timeout_exc = (state_q == TMO);

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: each operation is described as an event timeline whose
// outcome (write, div0, timeout, abort) is resolved by priority, then replayed cycle by cycle.
module tb_muldiv_seq;

  localparam int T = 8;

  logic clock = 1'b0;
  logic reset, op_valid, op_is_div, abort, mult_end, div_end, div_zero;
  logic op_ready, busy, mult_start, div_start, hilo_src;
  logic hi_write, lo_write, done, div0_exc, timeout_exc;
  logic [9:0] obs;

  int checks = 0;
  int errors = 0;
  bit last_kind = 1'b0;

  always #5 clock = ~clock;

  muldiv_seq #(.TIMEOUT(T)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_is_div(op_is_div),
    .abort(abort), .mult_end(mult_end), .div_end(div_end), .div_zero(div_zero),
    .op_ready(op_ready), .busy(busy), .mult_start(mult_start), .div_start(div_start),
    .hilo_src(hilo_src), .hi_write(hi_write), .lo_write(lo_write), .done(done),
    .div0_exc(div0_exc), .timeout_exc(timeout_exc)
  );

  assign obs = {op_ready, busy, mult_start, div_start, hilo_src,
                hi_write, lo_write, done, div0_exc, timeout_exc};

  // {op_ready, busy, mult_start, div_start, hilo_src, hi_write, lo_write, done, div0_exc, timeout_exc}
  function automatic logic [9:0] vec(bit rdy, bit bsy, bit ms, bit ds, bit src,
                                     bit wr, bit d0, bit tm);
    return {rdy, bsy, ms, ds, src, wr, wr, wr, d0, tm};
  endfunction

  task automatic chk(input string tag, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic o, input logic exp);
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic clr_inputs;
    op_valid = 1'b0; op_is_div = 1'b0; abort = 1'b0;
    mult_end = 1'b0; div_end = 1'b0; div_zero = 1'b0;
  endtask

  // WAIT-cycle indices w (0..T-1) map to absolute cycle 2+w; -1 means no event.
  // res: 0 = write, 1 = div0, 2 = timeout, 3 = aborted.
  task automatic run_op(input string name, input bit kind, input bit ab_start,
                        input int ab_w, input int end_w, input int zero_w, input int wrong_w);
    int outc;
    int res;
    outc = -1;
    res  = 0;
    if (ab_start) begin
      outc = 1; res = 3;
    end else begin
      for (int w = 0; w < T && outc < 0; w++) begin
        if (w == ab_w) begin
          outc = 2 + w; res = 3;
        end else if (kind && w == zero_w) begin
          outc = 3 + w; res = 1;
        end else if (w == end_w) begin
          outc = 3 + w; res = 0;
        end
      end
    end
    if (outc < 0) begin
      outc = 2 + T; res = 2;
    end

    for (int c = 0; c <= outc; c++) begin
      int w;
      bit in_wait, sel, wrong, zero;
      logic [9:0] exp;
      w       = c - 2;
      in_wait = (c >= 2) && (res == 3 || c < outc);
      op_valid  = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      op_is_div = (c == 0) ? kind : 1'($urandom_range(0, 1));
      if (c == 0)       abort = 1'($urandom_range(0, 1));
      else if (c == 1)  abort = ab_start;
      else if (in_wait) abort = (w == ab_w);
      else              abort = 1'($urandom_range(0, 1));
      sel   = in_wait ? (w == end_w) : 1'($urandom_range(0, 1));
      zero  = in_wait ? (w == zero_w) : 1'($urandom_range(0, 1));
      wrong = (in_wait && w == wrong_w) || ($urandom_range(0, 3) == 0);
      mult_end = kind ? wrong : sel;
      div_end  = kind ? sel : wrong;
      div_zero = kind ? zero : 1'($urandom_range(0, 1));

      if (c == 0)                     exp = vec(1, 0, 0, 0, last_kind, 0, 0, 0);
      else if (c == 1)                exp = vec(0, 1, !kind, kind, kind, 0, 0, 0);
      else if (c < outc || res == 3)  exp = vec(0, 1, 0, 0, kind, 0, 0, 0);
      else if (res == 0)              exp = vec(0, 1, 0, 0, kind, 1, 0, 0);
      else if (res == 1)              exp = vec(0, 1, 0, 0, kind, 0, 1, 0);
      else                            exp = vec(0, 1, 0, 0, kind, 0, 0, 1);

      @(negedge clock);
      chk($sformatf("%s c%0d", name, c), exp);
      next_cycle();
    end
    last_kind = kind;
  endtask

  initial begin
    clr_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    chk("reset_idle", vec(1, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();

    run_op("mult_c5",      0, 0, -1,  3, -1, -1);
    run_op("div_zero_c3",  1, 0, -1,  1,  1, -1);
    run_op("mult_tmo",     0, 0, -1, -1, -1, -1);
    run_op("mult_end_c9",  0, 0, -1,  7, -1, -1);
    run_op("div_wrong",    1, 0, -1,  6, -1,  2);
    run_op("abort_c3",     1, 0,  1,  5, -1, -1);
    run_op("abort_start",  0, 1, -1,  0, -1, -1);
    run_op("div_tmo",      1, 0, -1, -1, -1, -1);
    run_op("div_end_first",1, 0, -1,  2,  5, -1);
    run_op("div_end_last", 1, 0, -1,  7, -1, -1);

    // Reset while a divide sits in WAIT, with div_end offered during reset.
    clr_inputs();
    op_valid = 1'b1; op_is_div = 1'b1;
    next_cycle();
    clr_inputs();
    next_cycle();
    next_cycle();
    reset = 1'b1; div_end = 1'b1;
    @(negedge clock);
    chk1("rst_mid c3 hi_write", hi_write, 1'b0);
    next_cycle();
    div_end = 1'b0;
    @(negedge clock);
    chk1("rst_mid c4 hi_write", hi_write, 1'b0);
    chk("rst_mid c4", vec(1, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid c5", vec(1, 0, 0, 0, 0, 0, 0, 0));
    last_kind = 1'b0;
    next_cycle();

    for (int i = 0; i < 40; i++) begin
      bit k, abs;
      int abw, ew, zw;
      k   = 1'($urandom_range(0, 1));
      abs = ($urandom_range(0, 15) == 0);
      abw = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, T - 1)) : -1;
      ew  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, T - 1));
      zw  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, T - 1)) : -1;
      run_op($sformatf("rnd%0d", i), k, abs, abw, ew, zw, -1);
    end

    clr_inputs();
    @(negedge clock);
    chk("final_idle", vec(1, 0, 0, 0, last_kind, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Sequencer for the CPU's multiply and divide units and the HIGH/LOW register pair. Accepts one mult/div request at a time from the main control FSM, pulses the selected unit's start line and waits for its completion. It then steers the unit's results through the HIGH/LOW input muxes and writes both registers. Divide-by-zero, a missing completion (timeout) and external abort are reported or handled without corrupting HIGH/LOW.

## Interface
Parameters:
- TIMEOUT, 64: maximum WAIT cycles before a timeout is declared; legal range ≥ 2.
- CNT_W, $clog2(TIMEOUT+1): width of the wait counter (derived; do not override).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  request from main control; sampled only in IDLE.
- op_is_div  in  1  0 = mult, 1 = div; sampled with op_valid.
- abort  in  1  cancel an in-flight operation (exception/flush).
- mult_end  in  1  multiplier finished, results valid this cycle.
- div_end  in  1  divider finished, results valid this cycle.
- div_zero  in  1  divider detected divisor = 0.
- op_ready  out  1  high in IDLE only.
- busy  out  1  high in every state except IDLE.
- mult_start  out  1  one-cycle start pulse to the multiplier.
- div_start  out  1  one-cycle start pulse to the divider.
- hilo_src  out  1  HIGH/LOW input mux select: 0 = multiplier, 1 = divider.
- hi_write  out  1  HIGH register load enable.
- lo_write  out  1  LOW register load enable.
- done  out  1  one-cycle completion pulse.
- div0_exc  out  1  one-cycle divide-by-zero exception pulse.
- timeout_exc  out  1  one-cycle timeout exception pulse.

## Operation
- All outputs are Moore, decoded from the state register plus the latched `kind` bit. `kind` is captured from op_is_div on acceptance.
- States and transitions:
  - IDLE: op_ready = 1. If op_valid → START and latch kind. Otherwise stay. abort is ignored here.
  - START: assert mult_start if kind = 0, otherwise div_start. Clear the counter. If abort → IDLE, else → WAIT.
  - WAIT: only the selected unit's inputs count. mult_end is ignored during a div, and div_end/div_zero are ignored during a mult. Priority within the cycle:
    1. abort → IDLE.
    2. kind = 1 and div_zero → DIV0. This applies even if div_end is also high.
    3. Selected end → WRITE.
    4. cnt == TIMEOUT-1 → TMO.
    5. Otherwise cnt++.
  - WRITE: hi_write = lo_write = done = 1, hilo_src = kind. → IDLE.
  - DIV0: div0_exc = 1, no writes. → IDLE.
  - TMO: timeout_exc = 1, no writes. → IDLE.
- hilo_src is driven from kind in every state; it only matters in WRITE.
- op_valid outside IDLE is ignored, not queued. The requester must hold op_valid until op_ready is seen.
- hi_write and lo_write are always asserted together.

## Timing
- Reset:
  - State → IDLE, kind = 0, cnt = 0.
  - Outputs in the cycle after reset: op_ready = 1, all other outputs 0.
  - Reset mid-operation drops the operation with no write and no exception pulse.
- Acceptance at cycle 0 gives START at cycle 1 (start pulse) and WAIT from cycle 2.
- Selected end at cycle k gives WRITE at k+1. HIGH/LOW are updated at the k+1 edge, and op_ready returns at k+2.
- Minimum turnaround: a new op_valid can be accepted at k+2.
- Timeout: exactly TIMEOUT WAIT cycles without an event, so TMO occurs at cycle 2+TIMEOUT. An end arriving in the last WAIT cycle wins over the timeout.
- The counter never wraps: it saturates by leaving WAIT.

## Structure
- Shared package `muldiv_pkg`:
  - state enum `muldiv_state_t` {IDLE, START, WAIT, WRITE, DIV0, TMO}.
  - constants HILO_SRC_MULT = 1'b0 and HILO_SRC_DIV = 1'b1, also used by the HIGH/LOW mux instances in the CPU top.
- Single module: one state register, the kind bit and one counter. No sub-module.

## Test plan
- Reset: hold reset for 2 cycles while in WAIT → next cycle op_ready = 1, busy = 0, all pulses 0, and hi_write never asserted.
- Mult: op_valid=1, op_is_div=0 at c0, mult_end at c5 → mult_start at c1 only; hi_write = lo_write = done = 1 with hilo_src = 0 at c6; op_ready = 1 at c7.
- Divide by zero: div accepted at c0, div_zero = div_end = 1 at c3 → div0_exc at c4; no hi_write/lo_write/done; IDLE at c5.
- Timeout: TIMEOUT = 8, mult accepted at c0, no end → timeout_exc at c10 only, no writes. Repeat with mult_end at c9 → WRITE at c10, no timeout_exc.
- Wrong unit: div in flight, mult_end pulses at c4, div_end at c8 → no action at c4; WRITE with hilo_src = 1 at c9.
- Abort and busy:
  - abort at c3 in WAIT → IDLE at c4 with no pulses.
  - op_valid held at c1–c3 during a busy op → exactly one operation executes; the new op is accepted only once IDLE is reached.
